// File: rtl/ram_arbiter.sv
// Round-robin arbiter owning a 2**ADDR_W x DATA_W RAM, shared between CPU and host.
// Define MEM_ARB_LOCK_EN to build the host lock (LOCK / LOCK_WAIT states and lock counter).
module ram_arbiter #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_rvalid,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              h_lock,
  output logic              h_gnt,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_rvalid,
  output logic              owner,
  output logic              locked
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ARB,
    LOCK,
    LOCK_WAIT
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic c_win, h_win;

  // Grant decision is combinational; nothing is granted while reset is held.
  always_comb begin
    c_win = 1'b0;
    h_win = 1'b0;
    if (!reset) begin
      if (state == LOCK) begin
        h_win = h_req;
      end else if (c_req && h_req) begin
        c_win = owner;
        h_win = !owner;
      end else begin
        c_win = c_req;
        h_win = h_req;
      end
    end
  end

  assign c_gnt = c_win;
  assign h_gnt = h_win;

`ifdef MEM_ARB_LOCK_EN
  localparam logic [7:0] MAX_CNT = MAX_LOCK[7:0];

  logic [7:0] lock_cnt, lock_cnt_nx, lock_cnt_inc;

  assign lock_cnt_inc = (lock_cnt == MAX_CNT) ? lock_cnt : lock_cnt + 8'd1;

  always_comb begin
    state_nx    = state;
    lock_cnt_nx = lock_cnt;
    unique case (state)
      ARB: begin
        lock_cnt_nx = '0;
        if (h_win && h_lock) begin
          lock_cnt_nx = 8'd1;
          state_nx    = (MAX_CNT <= 8'd1) ? LOCK_WAIT : LOCK;
        end
      end
      LOCK: begin
        if (!h_lock) begin
          state_nx = ARB;
        end else if (h_win) begin
          lock_cnt_nx = lock_cnt_inc;
          if (lock_cnt_inc == MAX_CNT) state_nx = LOCK_WAIT;
        end
      end
      LOCK_WAIT: begin
        if (!h_lock) state_nx = ARB;
      end
      default: begin
        state_nx    = ARB;
        lock_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) lock_cnt <= '0;
    else       lock_cnt <= lock_cnt_nx;
  end

  assign locked = (state == LOCK);
`else
  logic unused_lock;

  assign unused_lock = h_lock;

  always_comb begin
    state_nx = ARB;
  end

  assign locked = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB;
      owner    <= 1'b1;
      c_rdata  <= '0;
      c_rvalid <= 1'b0;
      h_rdata  <= '0;
      h_rvalid <= 1'b0;
    end else begin
      state    <= state_nx;
      c_rvalid <= c_win && !c_we;
      h_rvalid <= h_win && !h_we;
      if (c_win)            owner   <= 1'b0;
      else if (h_win)       owner   <= 1'b1;
      if (c_win && !c_we)   c_rdata <= mem[c_addr];
      if (h_win && !h_we)   h_rdata <= mem[h_addr];
    end
  end

  // RAM contents survive reset; grants are already gated by reset.
  always_ff @(posedge clk) begin
    if (c_win && c_we)      mem[c_addr] <= c_wdata;
    else if (h_win && h_we) mem[h_addr] <= h_wdata;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter, checked against a behavioural model.
// Honours MEM_ARB_LOCK_EN in the model exactly as the design does.
module tb_ram_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned ML = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, h_req, h_we, h_lock;
  logic [AW-1:0] c_addr, h_addr;
  logic [DW-1:0] c_wdata, h_wdata;
  logic          c_gnt, h_gnt, c_rvalid, h_rvalid, owner, locked;
  logic [DW-1:0] c_rdata, h_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_lock(h_lock), .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .owner(owner), .locked(locked)
  );

  // Reference model: mode 0 = free round-robin, 1 = host exclusive, 2 = cool-down.
  logic [DW-1:0] m_mem [16];
  bit            m_known [16];
  int            m_owner, m_mode, m_cnt;
  bit            e_crv, e_hrv, e_ck, e_hk;
  logic [DW-1:0] e_crd, e_hrd;
  bit            last_c, last_h;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit cr, input bit cw, input int ca, input int cd,
                       input bit hr, input bit hw, input int ha, input int hd, input bit hl);
    c_req = cr; c_we = cw; c_addr = AW'(ca); c_wdata = DW'(cd);
    h_req = hr; h_we = hw; h_addr = AW'(ha); h_wdata = DW'(hd); h_lock = hl;
  endtask

  task automatic step();
    bit ec, eh;
    #1;
    ec = 1'b0;
    eh = 1'b0;
    if (!reset) begin
      if (m_mode == 1) eh = h_req;
      else if (c_req && h_req) begin
        if (m_owner == 1) ec = 1'b1;
        else eh = 1'b1;
      end else begin
        ec = c_req;
        eh = h_req;
      end
    end
    check("c_gnt", c_gnt, ec);
    check("h_gnt", h_gnt, eh);
    check("one_gnt", c_gnt & h_gnt, 0);
    check("locked", locked, m_mode == 1);
    check("owner", owner, m_owner);
    last_c = c_gnt;
    last_h = h_gnt;
    if (reset) begin
      m_owner = 1; m_mode = 0; m_cnt = 0;
      e_crv = 0; e_hrv = 0; e_crd = '0; e_hrd = '0; e_ck = 1; e_hk = 1;
    end else begin
      e_crv = ec && !c_we;
      e_hrv = eh && !h_we;
      if (e_crv) begin e_crd = m_mem[c_addr]; e_ck = m_known[c_addr]; end
      if (e_hrv) begin e_hrd = m_mem[h_addr]; e_hk = m_known[h_addr]; end
      if (ec && c_we) begin m_mem[c_addr] = c_wdata; m_known[c_addr] = 1; end
      if (eh && h_we) begin m_mem[h_addr] = h_wdata; m_known[h_addr] = 1; end
      if (ec) m_owner = 0;
      if (eh) m_owner = 1;
`ifdef MEM_ARB_LOCK_EN
      case (m_mode)
        0: if (eh && h_lock) begin
             m_cnt  = 1;
             m_mode = (ML <= 1) ? 2 : 1;
           end
        1: if (!h_lock) m_mode = 0;
           else if (eh) begin
             if (m_cnt < ML) m_cnt++;
             if (m_cnt == ML) m_mode = 2;
           end
        default: if (!h_lock) m_mode = 0;
      endcase
`endif
    end
    @(posedge clk);
    #1;
    check("c_rvalid", c_rvalid, e_crv);
    check("h_rvalid", h_rvalid, e_hrv);
    if (e_ck) check("c_rdata", c_rdata, e_crd);
    if (e_hk) check("h_rdata", h_rdata, e_hrd);
  endtask

  initial begin
    int run, best, exp_run;
    for (int i = 0; i < 16; i++) begin m_mem[i] = '0; m_known[i] = 0; end
    m_owner = 1; m_mode = 0; m_cnt = 0;
    e_crv = 0; e_hrv = 0; e_crd = '0; e_hrd = '0; e_ck = 0; e_hk = 0;
    reset = 1'b1;
    drive(1, 0, 1, 0, 1, 1, 2, 8'h55, 1);
    @(posedge clk);
    #1;
    step();
    step();
    check("rst_c_rdata", c_rdata, 0);
    check("rst_owner", owner, 1);
    reset = 1'b0;

    // Host write then CPU read of the same word
    drive(0, 0, 0, 0, 1, 1, 3, 8'hA5, 0);
    step();
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0);
    step();
    check("rd_a5_valid", c_rvalid, 1);
    check("rd_a5_data", c_rdata, 8'hA5);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int a = 0; a < 16; a++) begin
      drive(0, 0, 0, 0, 1, 1, a, $urandom_range(0, 255), 0);
      step();
    end

    // Continuous contention from reset alternates C,H,...
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, $urandom_range(0, 15), 0, 1, 0, $urandom_range(0, 15), 0, 0);
      step();
      check("alt_c", last_c, (i % 2) == 0);
    end

    // Locked host burst against a constantly requesting CPU
    reset = 1'b1;
    step();
    reset = 1'b0;
    run = 0;
    best = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, $urandom_range(0, 15), 0, 1, 1, $urandom_range(0, 14), $urandom_range(0, 255), 1);
      step();
      run = last_h ? run + 1 : 0;
      if (run > best) best = run;
    end
`ifdef MEM_ARB_LOCK_EN
    exp_run = ML;
`else
    exp_run = 1;
`endif
    check("lock_run", best, exp_run);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Host drops the lock after three locked writes
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 1, 1, $urandom_range(0, 14), $urandom_range(0, 255), 1);
      step();
    end
    drive(1, 0, 0, 0, 1, 1, 5, 8'h11, 0);
    step();
    step();
    step();

    // Reset in the middle of a locked burst leaves RAM intact
    drive(1, 1, 15, 8'h3C, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 1, 1, $urandom_range(0, 14), $urandom_range(0, 255), 1);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_locked", locked, 0);
    check("mid_rst_rvalid", c_rvalid, 0);
    drive(1, 0, 15, 0, 0, 0, 0, 0, 0);
    step();
    check("rd_3c", c_rdata, 8'h3C);

    // Random traffic with a sticky lock request
    h_lock = 1'b0;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
            ($urandom_range(0, 7) == 0) ? !h_lock : h_lock);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
